// File: rtl/d_cache_tag_ctrl.sv
// d_cache_tag_ctrl: pipeline-side controller for the 64-set D-cache tag RAM.
// Ports: lookup req/resp (hit, victim valid/tag), refill install, flush walk
// control/status, tag RAM drive (addr/wdata/we) and read-back, hit/miss stats.
// Latency: lookup response two cycles after accept; refill 1 cycle; flush 64 cycles.
// Backpressure: req_ready/refill_ready low outside IDLE or while a flush is pending.
// Optional statistics counters are built only when D_CACHE_TAG_STAT_EN is defined.
module d_cache_tag_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    output logic        resp_hit,
    output logic        resp_victim_valid,
    output logic [54:0] resp_victim_tag,
    input  logic        refill_valid,
    output logic        refill_ready,
    input  logic [63:0] refill_addr,
    input  logic        flush_req,
    output logic        flush_busy,
    output logic        flush_done,
    output logic [5:0]  tag_addr_o,
    output logic [55:0] tag_wdata_o,
    output logic        tag_we_o,
    input  logic [54:0] tag_data_i,
    input  logic        tag_valid_i,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  flush_cnt;
    logic        flush_pend;
    logic        flush_pend_eff;
    logic [54:0] lookup_tag;
    logic        lookup_hit;

    // Line offsets play no part in tag lookup.
    logic offset_unused;
    assign offset_unused = ^{req_addr[2:0], refill_addr[2:0]};

    // A pulse arriving this very cycle counts as pending so that an IDLE
    // cycle never accepts a refill or lookup alongside a new flush request.
    assign flush_pend_eff = flush_pend | flush_req;
    assign flush_busy     = (state == ST_FLUSH);
    assign lookup_hit     = tag_valid_i & (tag_data_i == lookup_tag);

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        refill_ready = 1'b0;
        tag_we_o     = 1'b0;
        tag_addr_o   = 6'd0;
        tag_wdata_o  = 56'd0;
        case (state)
            ST_FLUSH: begin
                tag_we_o   = 1'b1;
                tag_addr_o = flush_cnt;
                if (flush_cnt == 6'd63) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_pend_eff) begin
                    state_nxt = ST_FLUSH;
                end else if (refill_valid) begin
                    refill_ready = 1'b1;
                    tag_we_o     = 1'b1;
                    tag_addr_o   = refill_addr[8:3];
                    tag_wdata_o  = {1'b1, refill_addr[63:9]};
                end else begin
                    // Address is presented while idle so the RAM read is
                    // already under way on the accepting edge.
                    req_ready  = 1'b1;
                    tag_addr_o = req_addr[8:3];
                    if (req_valid) begin
                        state_nxt = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_FLUSH;
            flush_cnt         <= 6'd0;
            flush_pend        <= 1'b0;
            flush_done        <= 1'b0;
            lookup_tag        <= 55'd0;
            resp_valid        <= 1'b0;
            resp_hit          <= 1'b0;
            resp_victim_valid <= 1'b0;
            resp_victim_tag   <= 55'd0;
        end else begin
            state      <= state_nxt;
            flush_done <= (state == ST_FLUSH) && (flush_cnt == 6'd63);
            // Wraps back to 0 after entry 63, ready for the next walk.
            if (state == ST_FLUSH) begin
                flush_cnt <= flush_cnt + 6'd1;
            end
            // Requests during a walk are absorbed by that walk.
            if ((state == ST_IDLE) && flush_pend_eff) begin
                flush_pend <= 1'b0;
            end else if ((state != ST_FLUSH) && flush_req) begin
                flush_pend <= 1'b1;
            end
            if (req_valid && req_ready) begin
                lookup_tag <= req_addr[63:9];
            end
            resp_valid <= (state == ST_LOOKUP);
            if (state == ST_LOOKUP) begin
                resp_hit          <= lookup_hit;
                resp_victim_valid <= tag_valid_i;
                resp_victim_tag   <= tag_data_i;
            end
        end
    end

`ifdef D_CACHE_TAG_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (resp_valid) begin
            if (resp_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_d_cache_tag_ctrl.sv
// Bench for d_cache_tag_ctrl: tag RAM model, set-array reference model,
// expected-response queue checked by an independent response monitor.
module tb_d_cache_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_victim_valid;
    logic [54:0] resp_victim_tag;
    logic        refill_valid = 1'b0;
    logic        refill_ready;
    logic [63:0] refill_addr = 64'd0;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic        flush_done;
    logic [5:0]  tag_addr_o;
    logic [55:0] tag_wdata_o;
    logic        tag_we_o;
    logic [54:0] tag_data_i;
    logic        tag_valid_i;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    d_cache_tag_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_victim_valid(resp_victim_valid), .resp_victim_tag(resp_victim_tag),
        .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_addr(refill_addr),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o), .tag_we_o(tag_we_o),
        .tag_data_i(tag_data_i), .tag_valid_i(tag_valid_i),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tag RAM: no reset, registered read, output held on write cycles.
    logic [55:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    end
    always @(posedge clk) begin
        if (tag_we_o) mem[tag_addr_o] <= tag_wdata_o;
        else {tag_valid_i, tag_data_i} <= mem[tag_addr_o];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per-set valid/tag, cleared by flush or reset.
    typedef struct {
        logic        hit;
        logic        vv;
        logic [54:0] vtag;
        int          cyc;
    } exp_t;

    logic        m_valid [64];
    logic [54:0] m_tag   [64];
    exp_t        expq[$];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 55'd0;
        end
    endtask

    initial model_clear();

    // Observer: records handshakes into the model / expected queue.
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        if (rst) begin
            model_clear();
            expq.delete();
            exp_hits   = 0;
            exp_misses = 0;
        end else begin
            if (flush_req) model_clear();
            if (refill_valid && refill_ready) begin
                idx = int'(refill_addr[8:3]);
                m_valid[idx] = 1'b1;
                m_tag[idx]   = refill_addr[63:9];
            end
            if (req_valid && req_ready) begin
                idx    = int'(req_addr[8:3]);
                e.vv   = m_valid[idx];
                e.vtag = m_tag[idx];
                e.hit  = m_valid[idx] && (m_tag[idx] == req_addr[63:9]);
                e.cyc  = cyc;
                expq.push_back(e);
            end
        end
    end

    // Monitor: compares every presented response with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                chk("resp_latency", 64'(cyc - e.cyc), 64'd2);
                chk("resp_hit", 64'(resp_hit), 64'(e.hit));
                chk("resp_victim_valid", 64'(resp_victim_valid), 64'(e.vv));
                chk("resp_victim_tag", 64'(resp_victim_tag), 64'(e.vtag));
                if (e.hit) exp_hits++;
                else exp_misses++;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_refill_ready", 64'(refill_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(resp_hit), 64'd0);
        chk("rst_victim_valid", 64'(resp_victim_valid), 64'd0);
        chk("rst_victim_tag", 64'(resp_victim_tag), 64'd0);
        chk("rst_flush_busy", 64'(flush_busy), 64'd1);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        chk("rst_tag_we", 64'(tag_we_o), 64'd1);
        chk("rst_tag_addr", 64'(tag_addr_o), 64'd0);
        chk("rst_tag_wdata", 64'(tag_wdata_o), 64'd0);
    endtask

    // Checks the 64 zero writes; stop_at >= 0 returns after that entry.
    task automatic walk_check(input int stop_at);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("walk_we", 64'(tag_we_o), 64'd1);
            chk("walk_addr", 64'(tag_addr_o), 64'(i));
            chk("walk_wdata", 64'(tag_wdata_o), 64'd0);
            chk("walk_busy", 64'(flush_busy), 64'd1);
            chk("walk_done", 64'(flush_done), 64'd0);
            if (i == stop_at) return;
        end
        @(negedge clk);
        chk("walk_end_done", 64'(flush_done), 64'd1);
        chk("walk_end_req_ready", 64'(req_ready), 64'd1);
        chk("walk_end_busy", 64'(flush_busy), 64'd0);
        @(negedge clk);
        chk("walk_done_pulse", 64'(flush_done), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_refill(input logic [63:0] a);
        bit ok = 0;
        refill_valid = 1'b1;
        refill_addr  = a;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (refill_ready) begin ok = 1; break; end
        end
        chk("refill_taken", 64'(ok), 64'd1);
        if (ok) begin
            chk("refill_we", 64'(tag_we_o), 64'd1);
            chk("refill_addr", 64'(tag_addr_o), 64'(a[8:3]));
            chk("refill_wdata", 64'(tag_wdata_o), 64'({1'b1, a[63:9]}));
        end
        @(posedge clk); #1;
        refill_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [63:0] a);
        bit ok = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        chk("lookup_taken", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [54:0] t;
        t = 55'($urandom_range(0, 3));
        if ($urandom % 2 == 1) t[54] = 1'b1;
        return (64'(t) << 9) | (64'($urandom_range(0, 7)) << 3) | 64'($urandom % 8);
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset partway through the first walk, then a full restarted walk.
        walk_check(20);
        #1 rst = 1'b1;
        #2 check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        walk_check(-1);

        // Directed lookups on index 1.
        do_lookup(64'h1208);
        do_refill(64'h1208);
        do_lookup(64'h1208);
        do_lookup(64'h2208);

        // Flush, refill and lookup raised together in IDLE.
        flush_req    = 1'b1;
        refill_valid = 1'b1;
        refill_addr  = 64'h4_0010;
        req_valid    = 1'b1;
        req_addr     = 64'h4_0010;
        @(negedge clk);
        chk("simul_refill_ready", 64'(refill_ready), 64'd0);
        chk("simul_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("simul_walk_we", 64'(tag_we_o), 64'd1);
            chk("simul_walk_addr", 64'(tag_addr_o), 64'(i));
            chk("simul_walk_refill_ready", 64'(refill_ready), 64'd0);
        end
        @(negedge clk);
        chk("simul_done", 64'(flush_done), 64'd1);
        chk("simul_refill_first", 64'(refill_ready), 64'd1);
        chk("simul_req_held", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        refill_valid = 1'b0;
        @(negedge clk);
        chk("simul_req_next", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            req_valid    = ($urandom % 2) == 1;
            req_addr     = rnd_addr();
            refill_valid = ($urandom % 4) == 0;
            refill_addr  = rnd_addr();
            flush_req    = ($urandom % 150) == 0;
            @(posedge clk); #1;
        end
        req_valid    = 1'b0;
        refill_valid = 1'b0;
        flush_req    = 1'b0;
        repeat (80) begin @(posedge clk); #1; end

        chk("queue_drained", 64'(expq.size()), 64'd0);
`ifdef D_CACHE_TAG_STAT_EN
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
`else
        chk("hit_cnt_tied", 64'(hit_cnt), 64'd0);
        chk("miss_cnt_tied", 64'(miss_cnt), 64'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
